// File: rtl/json_stream_lexer.sv
// json_stream_lexer: byte-stream JSON tokenizer, one ASCII byte per cycle in,
// one token per handshake out, with payload length and nesting depth.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_data/in_last   byte stream (in_last marks document end)
//   tok_valid/tok_ready/tok_type/tok_len/tok_depth   token stream
//   err_valid/err_code             sticky error flag and code
//   done                           sticky clean end of document
module json_stream_lexer #(
    parameter  int unsigned MAX_DEPTH = 16,
    parameter  int unsigned LEN_W     = 16,
    localparam int unsigned DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [3:0]       tok_type,
    output logic [LEN_W-1:0] tok_len,
    output logic [DW-1:0]    tok_depth,
    output logic             err_valid,
    output logic [1:0]       err_code,
    output logic             done
);

    // Stack sized to the full depth-index range so depth_q indexes it directly
    localparam int unsigned SW = 2 ** DW;

    localparam logic [3:0] TOK_OBJ_BEGIN = 4'd0;
    localparam logic [3:0] TOK_OBJ_END   = 4'd1;
    localparam logic [3:0] TOK_ARR_BEGIN = 4'd2;
    localparam logic [3:0] TOK_ARR_END   = 4'd3;
    localparam logic [3:0] TOK_COLON     = 4'd4;
    localparam logic [3:0] TOK_COMMA     = 4'd5;
    localparam logic [3:0] TOK_STRING    = 4'd6;
    localparam logic [3:0] TOK_NUMBER    = 4'd7;
    localparam logic [3:0] TOK_TRUE      = 4'd8;
    localparam logic [3:0] TOK_FALSE     = 4'd9;
    localparam logic [3:0] TOK_NULL      = 4'd10;

    localparam logic [1:0] ERR_NWNF  = 2'd0;
    localparam logic [1:0] ERR_UNEXP = 2'd1;
    localparam logic [1:0] ERR_NEST  = 2'd2;
    localparam logic [1:0] ERR_TRUNC = 2'd3;

    typedef enum logic [2:0] {
        S_SCAN, S_STRING, S_STR_ESC, S_NUMBER, S_LITERAL, S_ERROR, S_DONE
    } state_e;

    function automatic logic is_ws(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
    endfunction

    function automatic logic is_num(input logic [7:0] b);
        return ((b >= "0") && (b <= "9")) || (b == "-") || (b == "+") ||
               (b == ".") || (b == "e") || (b == "E");
    endfunction

    // Expected character of literal word sel (0 true, 1 false, 2 null) at pos
    function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [2:0] pos);
        logic [39:0] w;
        logic [7:0]  c;
        case (sel)
            2'd0:    w = {"true", 8'h00};
            2'd1:    w = "false";
            default: w = {"null", 8'h00};
        endcase
        case (pos)
            3'd0:    c = w[39:32];
            3'd1:    c = w[31:24];
            3'd2:    c = w[23:16];
            3'd3:    c = w[15:8];
            3'd4:    c = w[7:0];
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    state_e            state_q, state_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [SW-1:0]     stack_q, stack_d;      // 1 = array, 0 = object
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        lit_sel_q, lit_sel_d;
    logic [2:0]        lit_pos_q, lit_pos_d;
    logic [7:0]        replay_q, replay_d;
    logic              replay_full_q, replay_full_d;
    logic              replay_last_q, replay_last_d;
    logic              any_tok_q, any_tok_d;
    logic              tok_valid_q, tok_valid_d;
    logic [3:0]        tok_type_q, tok_type_d;
    logic [LEN_W-1:0]  tok_len_q, tok_len_d;
    logic [DW-1:0]     tok_depth_q, tok_depth_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              done_q, done_d;

    logic              live, tok_free, proc_en, cur_last, defer_last;
    logic [7:0]        cur_byte;
    logic [LEN_W-1:0]  len_inc;
    logic              emit, raise;
    logic [3:0]        emit_type;
    logic [LEN_W-1:0]  emit_len;
    logic [DW-1:0]     emit_depth;
    logic [1:0]        raise_code;

    assign live     = (state_q != S_ERROR) && (state_q != S_DONE);
    assign tok_free = !tok_valid_q || tok_ready;
    assign in_ready = tok_free && !replay_full_q && live;
    // A held replay byte takes priority; in_ready is low while it is held
    assign proc_en  = live && tok_free && (replay_full_q || in_valid);
    assign cur_byte = replay_full_q ? replay_q : in_data;
    assign cur_last = replay_full_q ? replay_last_q : in_last;
    assign len_inc  = (&len_q) ? len_q : len_q + LEN_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_SCAN;
            depth_q       <= '0;
            stack_q       <= '0;
            len_q         <= '0;
            lit_sel_q     <= '0;
            lit_pos_q     <= '0;
            replay_q      <= '0;
            replay_full_q <= 1'b0;
            replay_last_q <= 1'b0;
            any_tok_q     <= 1'b0;
            tok_valid_q   <= 1'b0;
            tok_type_q    <= '0;
            tok_len_q     <= '0;
            tok_depth_q   <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            depth_q       <= depth_d;
            stack_q       <= stack_d;
            len_q         <= len_d;
            lit_sel_q     <= lit_sel_d;
            lit_pos_q     <= lit_pos_d;
            replay_q      <= replay_d;
            replay_full_q <= replay_full_d;
            replay_last_q <= replay_last_d;
            any_tok_q     <= any_tok_d;
            tok_valid_q   <= tok_valid_d;
            tok_type_q    <= tok_type_d;
            tok_len_q     <= tok_len_d;
            tok_depth_q   <= tok_depth_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
            done_q        <= done_d;
        end
    end

    // Next-state: byte classification, stack, token load, error/end handling
    always_comb begin
        state_d       = state_q;
        depth_d       = depth_q;
        stack_d       = stack_q;
        len_d         = len_q;
        lit_sel_d     = lit_sel_q;
        lit_pos_d     = lit_pos_q;
        replay_d      = replay_q;
        replay_full_d = replay_full_q;
        replay_last_d = replay_last_q;
        any_tok_d     = any_tok_q;
        tok_valid_d   = tok_valid_q;
        tok_type_d    = tok_type_q;
        tok_len_d     = tok_len_q;
        tok_depth_d   = tok_depth_q;
        err_valid_d   = err_valid_q;
        err_code_d    = err_code_q;
        done_d        = done_q;
        emit          = 1'b0;
        emit_type     = TOK_OBJ_BEGIN;
        emit_len      = LEN_W'(1);
        emit_depth    = depth_q;
        raise         = 1'b0;
        raise_code    = ERR_NWNF;
        defer_last    = 1'b0;

        if (tok_valid_q && tok_ready) tok_valid_d = 1'b0;

        if (proc_en) begin
            replay_full_d = 1'b0;
            case (state_q)
                S_SCAN: begin
                    if (is_ws(cur_byte)) begin
                        // dropped
                    end else if ((cur_byte == "{") || (cur_byte == "[")) begin
                        if (depth_q == DW'(MAX_DEPTH)) begin
                            raise      = 1'b1;
                            raise_code = ERR_NEST;
                        end else begin
                            emit             = 1'b1;
                            emit_type        = (cur_byte == "[") ? TOK_ARR_BEGIN : TOK_OBJ_BEGIN;
                            stack_d[depth_q] = (cur_byte == "[");
                            depth_d          = depth_q + DW'(1);
                        end
                    end else if ((cur_byte == "}") || (cur_byte == "]")) begin
                        if ((depth_q == '0) ||
                            (stack_q[depth_q - DW'(1)] != (cur_byte == "]"))) begin
                            raise      = 1'b1;
                            raise_code = ERR_NEST;
                        end else begin
                            emit       = 1'b1;
                            emit_type  = (cur_byte == "]") ? TOK_ARR_END : TOK_OBJ_END;
                            depth_d    = depth_q - DW'(1);
                            emit_depth = depth_q - DW'(1);
                        end
                    end else if (cur_byte == ":") begin
                        emit      = 1'b1;
                        emit_type = TOK_COLON;
                    end else if (cur_byte == ",") begin
                        emit      = 1'b1;
                        emit_type = TOK_COMMA;
                    end else if (cur_byte == "\"") begin
                        state_d = S_STRING;
                        len_d   = '0;
                    end else if ((cur_byte == "-") || ((cur_byte >= "0") && (cur_byte <= "9"))) begin
                        len_d = LEN_W'(1);
                        if (cur_last) begin
                            emit      = 1'b1;
                            emit_type = TOK_NUMBER;
                        end else begin
                            state_d = S_NUMBER;
                        end
                    end else if ((cur_byte == "t") || (cur_byte == "f") || (cur_byte == "n")) begin
                        state_d   = S_LITERAL;
                        lit_pos_d = 3'd1;
                        lit_sel_d = (cur_byte == "t") ? 2'd0 : ((cur_byte == "f") ? 2'd1 : 2'd2);
                    end else begin
                        raise      = 1'b1;
                        raise_code = ERR_UNEXP;
                    end
                end
                S_STRING: begin
                    if (cur_byte < 8'h20) begin
                        raise      = 1'b1;
                        raise_code = ERR_UNEXP;
                    end else if (cur_byte == "\"") begin
                        emit      = 1'b1;
                        emit_type = TOK_STRING;
                        emit_len  = len_q;
                        state_d   = S_SCAN;
                    end else begin
                        len_d = len_inc;
                        if (cur_byte == "\\") state_d = S_STR_ESC;
                    end
                end
                S_STR_ESC: begin
                    len_d   = len_inc;
                    state_d = S_STRING;
                end
                S_NUMBER: begin
                    if (is_num(cur_byte)) begin
                        len_d = len_inc;
                        if (cur_last) begin
                            emit      = 1'b1;
                            emit_type = TOK_NUMBER;
                            emit_len  = len_inc;
                            state_d   = S_SCAN;
                        end
                    end else begin
                        // Terminator is re-run in SCAN once the token register frees
                        emit          = 1'b1;
                        emit_type     = TOK_NUMBER;
                        emit_len      = len_q;
                        state_d       = S_SCAN;
                        replay_d      = cur_byte;
                        replay_full_d = 1'b1;
                        replay_last_d = cur_last;
                        defer_last    = 1'b1;
                    end
                end
                S_LITERAL: begin
                    if (cur_byte != lit_char(lit_sel_q, lit_pos_q)) begin
                        raise      = 1'b1;
                        raise_code = ERR_UNEXP;
                    end else if (lit_pos_q == ((lit_sel_q == 2'd1) ? 3'd4 : 3'd3)) begin
                        emit      = 1'b1;
                        emit_len  = LEN_W'(lit_pos_q) + LEN_W'(1);
                        state_d   = S_SCAN;
                        case (lit_sel_q)
                            2'd0:    emit_type = TOK_TRUE;
                            2'd1:    emit_type = TOK_FALSE;
                            default: emit_type = TOK_NULL;
                        endcase
                    end else begin
                        lit_pos_d = lit_pos_q + 3'd1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            any_tok_d = any_tok_q | emit;

            if (emit) begin
                tok_valid_d = 1'b1;
                tok_type_d  = emit_type;
                tok_len_d   = emit_len;
                tok_depth_d = emit_depth;
            end

            // Byte-level errors outrank the end-of-document checks
            if (raise) begin
                state_d     = S_ERROR;
                err_valid_d = 1'b1;
                err_code_d  = raise_code;
            end else if (cur_last && !defer_last) begin
                if (!any_tok_d) begin
                    state_d     = S_ERROR;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_NWNF;
                end else if ((depth_d != '0) || (state_d == S_STRING) ||
                             (state_d == S_STR_ESC) || (state_d == S_LITERAL)) begin
                    state_d     = S_ERROR;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TRUNC;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign tok_valid = tok_valid_q;
    assign tok_type  = tok_type_q;
    assign tok_len   = tok_len_q;
    assign tok_depth = tok_depth_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign done      = done_q;

endmodule

// File: tb/tb_json_stream_lexer.sv
// tb_json_stream_lexer: directed-vector bench for json_stream_lexer.
// Two instances share one stimulus: u_dut (MAX_DEPTH=16) and u_dut_d2
// (MAX_DEPTH=2); sel picks which one is driven and observed.
module tb_json_stream_lexer;

    localparam int unsigned LEN_W = 16;
    localparam int unsigned DWA   = $clog2(16 + 1);
    localparam int unsigned DWB   = $clog2(2 + 1);

    logic             clk;
    logic             rst_n;
    logic             sel;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             tok_ready;
    logic             toggle;

    logic             a_in_ready, b_in_ready;
    logic             a_tok_valid, b_tok_valid;
    logic [3:0]       a_tok_type, b_tok_type;
    logic [LEN_W-1:0] a_tok_len, b_tok_len;
    logic [DWA-1:0]   a_tok_depth;
    logic [DWB-1:0]   b_tok_depth;
    logic             a_err_valid, b_err_valid;
    logic [1:0]       a_err_code, b_err_code;
    logic             a_done, b_done;

    logic             in_ready, tok_valid, err_valid, done;
    logic [3:0]       tok_type;
    logic [LEN_W-1:0] tok_len;
    logic [4:0]       tok_depth;
    logic [1:0]       err_code;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [31:0]      got_q[$];
    logic [31:0]      exp_q[$];

    json_stream_lexer #(.MAX_DEPTH(16), .LEN_W(LEN_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && !sel),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .tok_valid (a_tok_valid),
        .tok_ready (tok_ready && !sel),
        .tok_type  (a_tok_type),
        .tok_len   (a_tok_len),
        .tok_depth (a_tok_depth),
        .err_valid (a_err_valid),
        .err_code  (a_err_code),
        .done      (a_done)
    );

    json_stream_lexer #(.MAX_DEPTH(2), .LEN_W(LEN_W)) u_dut_d2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid && sel),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .tok_valid (b_tok_valid),
        .tok_ready (tok_ready && sel),
        .tok_type  (b_tok_type),
        .tok_len   (b_tok_len),
        .tok_depth (b_tok_depth),
        .err_valid (b_err_valid),
        .err_code  (b_err_code),
        .done      (b_done)
    );

    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign tok_valid = sel ? b_tok_valid : a_tok_valid;
    assign tok_type  = sel ? b_tok_type  : a_tok_type;
    assign tok_len   = sel ? b_tok_len   : a_tok_len;
    assign tok_depth = sel ? 5'(b_tok_depth) : a_tok_depth;
    assign err_valid = sel ? b_err_valid : a_err_valid;
    assign err_code  = sel ? b_err_code  : a_err_code;
    assign done      = sel ? b_done      : a_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tk(input int t, input int l, input int d);
        return {7'd0, t[3:0], l[15:0], d[4:0]};
    endfunction

    // Token collector and stall check, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && tok_valid && tok_ready)
            got_q.push_back({7'd0, tok_type, tok_len, tok_depth});
        if (rst_n && tok_valid && !tok_ready)
            chk("stall_in_ready", 32'(in_ready), 32'd0);
    end

    // Optional tok_ready toggling, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle) tok_ready = ~tok_ready;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last && (i == s.len() - 1));
    endtask

    task automatic chk_toks(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s_tok%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        sel       = 1'b0;
        toggle    = 1'b0;
        tok_ready = 1'b1;
        do_reset();

        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_tok_valid", 32'(tok_valid), 32'd0);
        chk("rst_tok_type",  32'(tok_type),  32'd0);
        chk("rst_tok_len",   32'(tok_len),   32'd0);
        chk("rst_tok_depth", 32'(tok_depth), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_code",  32'(err_code),  32'd0);
        chk("rst_done",      32'(done),      32'd0);

        // Object with string key and number value
        send_str("{\"ab\":12}", 1'b1);
        idle(4);
        exp_q.push_back(tk(0, 1, 0));
        exp_q.push_back(tk(6, 2, 1));
        exp_q.push_back(tk(4, 1, 1));
        exp_q.push_back(tk(7, 2, 1));
        exp_q.push_back(tk(1, 1, 0));
        chk_toks("obj");
        chk("obj_done", 32'(done),      32'd1);
        chk("obj_err",  32'(err_valid), 32'd0);

        // Literals with back-pressure
        do_reset();
        toggle = 1'b1;
        send_str("[true,null,false]", 1'b1);
        idle(10);
        toggle    = 1'b0;
        tok_ready = 1'b1;
        idle(2);
        exp_q.push_back(tk(2, 1, 0));
        exp_q.push_back(tk(8, 4, 1));
        exp_q.push_back(tk(5, 1, 1));
        exp_q.push_back(tk(10, 4, 1));
        exp_q.push_back(tk(5, 1, 1));
        exp_q.push_back(tk(9, 5, 1));
        exp_q.push_back(tk(3, 1, 0));
        chk_toks("lit");
        chk("lit_done", 32'(done), 32'd1);

        // Escaped quote inside a string
        do_reset();
        send_str("\"a\\\"b\"", 1'b0);
        idle(3);
        exp_q.push_back(tk(6, 4, 0));
        chk_toks("esc");
        chk("esc_err", 32'(err_valid), 32'd0);

        // Container kind mismatch via replayed terminator
        do_reset();
        send_str("[1}", 1'b0);
        idle(4);
        exp_q.push_back(tk(2, 1, 0));
        exp_q.push_back(tk(7, 1, 1));
        chk_toks("mism");
        chk("mism_err",   32'(err_valid), 32'd1);
        chk("mism_code",  32'(err_code),  32'd2);
        chk("mism_ready", 32'(in_ready),  32'd0);

        // Stack overflow on the MAX_DEPTH=2 instance
        sel = 1'b1;
        do_reset();
        send_str("[[[", 1'b0);
        idle(3);
        exp_q.push_back(tk(2, 1, 0));
        exp_q.push_back(tk(2, 1, 1));
        chk_toks("deep");
        chk("deep_err",  32'(err_valid), 32'd1);
        chk("deep_code", 32'(err_code),  32'd2);
        sel = 1'b0;

        // Whitespace-only document
        do_reset();
        send_str("  \n", 1'b1);
        idle(2);
        chk_toks("ws");
        chk("ws_err",  32'(err_valid), 32'd1);
        chk("ws_code", 32'(err_code),  32'd0);
        chk("ws_done", 32'(done),      32'd0);

        // Truncated inside a string
        do_reset();
        send_str("{\"x", 1'b1);
        idle(3);
        exp_q.push_back(tk(0, 1, 0));
        chk_toks("trunc");
        chk("trunc_err",  32'(err_valid), 32'd1);
        chk("trunc_code", 32'(err_code),  32'd3);

        // Bad literal
        do_reset();
        send_str("tru#", 1'b0);
        idle(2);
        chk_toks("badlit");
        chk("badlit_err",  32'(err_valid), 32'd1);
        chk("badlit_code", 32'(err_code),  32'd1);

        // Reset pulse mid-string, then a fresh one-number document
        do_reset();
        send_str("\"ab", 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tok_valid", 32'(tok_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_no_tok", 32'(got_q.size()), 32'd0);
        send_str("1 ", 1'b1);
        idle(3);
        exp_q.push_back(tk(7, 1, 0));
        chk_toks("midrst");
        chk("midrst_done", 32'(done),      32'd1);
        chk("midrst_err",  32'(err_valid), 32'd0);

        // Length saturation
        do_reset();
        send("\"", 1'b0);
        for (int i = 0; i < 70000; i++) send("a", 1'b0);
        send("\"", 1'b1);
        idle(3);
        exp_q.push_back(tk(6, 16'hFFFF, 0));
        chk_toks("sat");
        chk("sat_done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/json_stream_lexer.md
# json_stream_lexer

Synthesisable byte-stream JSON tokenizer: the hardware successor of the class-based decoder in `json_pkg`. It accepts one ASCII byte per cycle over a valid/ready stream and emits one token per handshake, with length and nesting depth attached. It tracks object/array nesting in a parametrised stack and reports errors using the `json_err_e` ordering, extended with nesting and truncation codes. It sits between a byte source (UART/AXI-stream adapter) and a downstream parser or loader that consumes tokens.

## Interface
- MAX_DEPTH, 16, maximum nesting levels held in the container stack (≥1).
- LEN_W, 16, width of token length counter.
- DW, $clog2(MAX_DEPTH+1), depth field width (derived, not overridable).
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_data  in  8  ASCII byte.
- in_last  in  1  marks the final byte of the document.
- tok_valid  out  1  token available.
- tok_ready  in  1  token consumed when tok_valid && tok_ready.
- tok_type  out  4  0 OBJ_BEGIN, 1 OBJ_END, 2 ARR_BEGIN, 3 ARR_END, 4 COLON, 5 COMMA, 6 STRING, 7 NUMBER, 8 TRUE, 9 FALSE, 10 NULL.
- tok_len  out  LEN_W  payload byte count; saturates at all-ones.
- tok_depth  out  DW  nesting level of the token; top level is 0.
- err_valid  out  1  sticky error flag.
- err_code  out  2  0 NON_WHITESPACE_NOT_FOUND, 1 UNEXPECTED_SYMBOL, 2 NESTING, 3 TRUNCATED.
- done  out  1  document ended cleanly (sticky).

## Operation
- FSM states: SCAN, STRING, STR_ESC, NUMBER, LITERAL, ERROR, DONE.
- **SCAN:** whitespace (0x20, 0x09, 0x0A, 0x0D) is dropped.
  - `{` and `[` emit their token at the current depth, push the container kind, and increment depth.
  - `}` and `]` pop the stack. A kind mismatch or an empty stack raises NESTING. The token is emitted at the post-pop depth.
  - `:` and `,` emit immediately.
  - `"` enters STRING.
  - `-` or a digit enters NUMBER with len=1.
  - `t`, `f`, `n` enter LITERAL with the expected word selected.
  - Any other byte raises UNEXPECTED_SYMBOL.
- **STRING:**
  - Each byte increments len.
  - `\` goes to STR_ESC. The next byte is counted raw and the FSM returns to STRING.
  - An unescaped `"` emits STRING with len equal to the raw bytes between the quotes.
  - Bytes below 0x20 raise UNEXPECTED_SYMBOL.
- **NUMBER:**
  - Accepts `0-9 - + . e E` and increments len.
  - Any other byte terminates the number and emits NUMBER. The terminator is stored in a 1-byte replay register and processed in SCAN once the token register is free.
  - Grammar inside the number is not checked.
- **LITERAL:** bytes are compared against a 3-bit index into "true", "false", "null".
  - The token is emitted on the final character match.
  - Any mismatch raises UNEXPECTED_SYMBOL.
- Structural grammar (comma or colon placement) is not checked. That is the consumer's job.
- **Push beyond MAX_DEPTH:** raises NESTING.
- **in_last handling:**
  - An in_last byte that is accepted is processed normally first. A terminating NUMBER is emitted on in_last.
  - After processing, if no token was ever emitted, raise NON_WHITESPACE_NOT_FOUND.
  - Otherwise, if depth≠0 or the FSM is in STRING, STR_ESC or LITERAL, raise TRUNCATED.
  - Otherwise go to DONE.
- **ERROR and DONE** are terminal until reset.
  - ERROR holds err_valid and err_code and keeps in_ready=0.
  - A token already pending in the token register is still delivered.
- **Error priority within one byte:** NESTING > UNEXPECTED_SYMBOL > TRUNCATED.

## Timing
- Reset values:
  - in_ready=1; tok_valid=0; tok_type/len/depth=0.
  - err_valid=0; err_code=0; done=0.
  - Depth=0, stack cleared, replay empty, state SCAN.
- Asserting rst_n low mid-document clears everything asynchronously. No partial token is emitted.
- in_ready = !(tok_valid && !tok_ready) && !replay_full && state∉{ERROR, DONE}. This is combinational from state and tok_ready.
- Throughput: 1 byte/cycle while tokens drain.
- Token latency: tok_valid rises the cycle after the terminating byte handshake. tok_* stay stable until the handshake.
- The token register is one deep. A new token may load in the same cycle as the previous one handshakes.
- Replay byte: processed in the first cycle where the token register is free. Its token appears ≥1 cycle after the NUMBER token.
- err_valid and done rise the cycle after the offending or last byte is accepted.

## Test plan
- `{"ab":12}` in_last on `}`, tok_ready=1 → OBJ_BEGIN d0, STRING len2 d1, COLON d1, NUMBER len2 d1, OBJ_END d0; then done=1, err_valid=0.
- `[true,null,false]` with tok_ready toggling 1/0 → TRUE, COMMA, NULL, COMMA, FALSE at d1, ARR_BEGIN/ARR_END at d0; in_ready=0 whenever the token is stalled; no token lost.
- `"a\"b"` → single STRING len=4; `[1}` → ARR_BEGIN, NUMBER len1, then err_code=2, in_ready=0.
- MAX_DEPTH=2, `[[[` → two ARR_BEGIN (d0, d1), third byte gives err_code=2; whitespace-only `"  \n"` with in_last → err_code=0.
- `{"x` with in_last → OBJ_BEGIN, then err_code=3, no STRING token; `tru#` → err_code=1.
- rst_n pulsed low mid-string, then `1 ` with in_last → only NUMBER len1 d0, done=1; 70000-byte string with LEN_W=16 → tok_len=0xFFFF.
